// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin write-back arbiter that serialises four register-file
// write requesters through a one-cycle mux-settling SETUP and a one-cycle WRITE.
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous, active-low reset
//   req[3:0]  - per-requester write-back request, level-held until grant
//   dest[19:0]- four 5-bit destination registers, requester i at [5i+4:5i]
//   flush     - aborts a transaction still in SETUP; blocks latching in IDLE
//   grant[3:0]- one-hot commit pulse, high only in WRITE
//   mux_sel   - selector code for mux_MEM_to_REG
//   reg_dst   - register-file write address
//   reg_write - register-file write enable (never for $zero)
//   busy      - high whenever the arbiter is not IDLE
module wb_arbiter #(
    parameter logic [3:0] SEL_R0 = 4'd0,
    parameter logic [3:0] SEL_R1 = 4'd1,
    parameter logic [3:0] SEL_R2 = 4'd2,
    parameter logic [3:0] SEL_R3 = 4'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [19:0] dest,
    input  logic        flush,
    output logic [3:0]  grant,
    output logic [3:0]  mux_sel,
    output logic [4:0]  reg_dst,
    output logic        reg_write,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;
    state_t      r_state, w_next;
    logic [1:0]  r_win, r_last, w_win;
    logic [4:0]  r_dst, w_dst;
    logic [3:0]  r_sel, w_sel, w_req;
    logic        w_latch;
    // The committing requester still holds req during WRITE, so it is masked
    // out of the decision for the next winner.
    assign w_req = (r_state == WRITE) ? (req & ~(4'b0001 << r_win)) : req;
    // Search order last+1, last+2, last+3, last; scanning backwards lets the
    // earliest position in that order overwrite the others.
    always_comb begin
        w_win = r_last;
        for (int k = 4; k >= 1; k--)
            if (w_req[r_last + 2'(k)]) w_win = r_last + 2'(k);
    end
    assign w_sel = (w_win == 2'd0) ? SEL_R0 :
                   (w_win == 2'd1) ? SEL_R1 :
                   (w_win == 2'd2) ? SEL_R2 : SEL_R3;
    assign w_dst = dest[5*w_win +: 5];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            IDLE: begin
                w_latch = |w_req && !flush;
                w_next  = w_latch ? SETUP : IDLE;
            end
            SETUP: w_next = flush ? IDLE : WRITE;
            WRITE: begin
                w_latch = |w_req;
                w_next  = w_latch ? SETUP : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win  <= 2'd0;
            r_dst  <= 5'd0;
            r_sel  <= 4'd0;
            r_last <= 2'd3;
        end else begin
            if (w_latch) begin
                r_win <= w_win;
                r_dst <= w_dst;
                r_sel <= w_sel;
            end
            // Priority only rotates once a transaction is committed to WRITE.
            if (r_state == SETUP && !flush) r_last <= r_win;
        end
    end
    always_comb begin
        busy      = r_state != IDLE;
        mux_sel   = busy ? r_sel : 4'd0;
        reg_dst   = busy ? r_dst : 5'd0;
        reg_write = (r_state == WRITE) && (r_dst != 5'd0);
        grant     = (r_state == WRITE) ? (4'b0001 << r_win) : 4'd0;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a
// transaction-level round-robin reference model.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [19:0] dest = 20'd0;
    logic [3:0]  grant, mux_sel;
    logic [4:0]  reg_dst;
    logic        reg_write, busy;

    wb_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .dest(dest), .flush(flush),
        .grant(grant), .mux_sel(mux_sel), .reg_dst(reg_dst),
        .reg_write(reg_write), .busy(busy)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    int selc[4] = '{0, 1, 2, 8};
    // Model: phase 0 = idle, 1 = mux settling, 2 = committing write.
    int m_ph, m_win, m_last;
    logic [4:0] m_dst;
    logic [3:0] g_cur, g_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] rq);
        for (int k = 1; k <= 4; k++)
            if (rq[(m_last + k) % 4]) return (m_last + k) % 4;
        return 0;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_last = 3; m_win = 0; m_dst = 5'd0; g_cur = 4'd0; g_prev = 4'd0;
    endtask

    task automatic model_edge();
        logic [3:0] rq;
        rq = req;
        if (m_ph == 0) begin
            if (rq != 0 && !flush) begin
                m_win = pick(rq); m_dst = dest[m_win*5 +: 5]; m_ph = 1;
            end
        end else if (m_ph == 1) begin
            if (flush) m_ph = 0;
            else begin m_ph = 2; m_last = m_win; end
        end else begin
            rq[m_win] = 1'b0;
            if (rq != 0) begin
                m_win = pick(rq); m_dst = dest[m_win*5 +: 5]; m_ph = 1;
            end else m_ph = 0;
        end
    endtask

    task automatic check_model();
        chk("busy", busy, m_ph != 0);
        chk("mux_sel", mux_sel, m_ph == 0 ? 0 : selc[m_win]);
        chk("reg_dst", reg_dst, m_ph == 0 ? 0 : m_dst);
        chk("reg_write", reg_write, m_ph == 2 && m_dst != 0);
        chk("grant", grant, m_ph == 2 ? (1 << m_win) : 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        g_prev = g_cur;
        if (reset) model_edge();
        #1;
        check_model();
        g_cur = (m_ph == 2) ? 4'(1 << m_win) : 4'd0;
    endtask

    // Requesters release req in the cycle after their grant.
    task automatic nxt();
        @(negedge clk);
        req = req & ~g_prev;
        flush = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b0;
        #1;
        check_model();
        chk("rst_last_prio", 32'(m_last), 32'd3);
        @(negedge clk) reset = 1'b1;

        // Full contention: 0,1,2,3 back to back.
        nxt();
        req = 4'hF; dest = {5'd4, 5'd3, 5'd2, 5'd1};
        for (int k = 0; k < 8; k++) begin
            if (k > 0) nxt();
            cyc();
            chk("rr_busy", busy, 1);
            if (k % 2 == 1) begin
                chk("rr_grant", grant, 1 << (k / 2));
                chk("rr_sel", mux_sel, selc[k / 2]);
            end
        end
        nxt(); cyc();
        chk("rr_idle", busy, 0);
        nxt(); cyc();

        // Single requester 1, dest 9.
        nxt();
        req = 4'b0010; dest = {5'd0, 5'd0, 5'd9, 5'd0};
        cyc();
        chk("r1_setup_sel", mux_sel, 1);
        chk("r1_setup_dst", reg_dst, 9);
        chk("r1_setup_we", reg_write, 0);
        nxt(); cyc();
        chk("r1_we", reg_write, 1);
        chk("r1_grant", grant, 4'b0010);
        nxt(); cyc();

        // Round-robin wrap after requester 1 wins.
        nxt();
        req = 4'b0011; dest = {5'd0, 5'd0, 5'd6, 5'd4};
        cyc();
        nxt(); cyc();
        chk("wrap_grant0", grant, 4'b0001);
        nxt(); cyc();
        chk("wrap_no_idle", busy, 1);
        nxt(); cyc();
        chk("wrap_grant1", grant, 4'b0010);
        nxt(); cyc();
        nxt(); cyc();

        // dest 0: grant without write.
        nxt();
        req = 4'b0001; dest = 20'd0;
        cyc();
        chk("zero_setup_we", reg_write, 0);
        nxt(); cyc();
        chk("zero_grant", grant, 4'b0001);
        chk("zero_we", reg_write, 0);
        nxt(); cyc();
        nxt(); cyc();

        // Flush in SETUP, then normal service.
        nxt();
        req = 4'b0100; dest = {5'd0, 5'd7, 5'd0, 5'd0};
        cyc();
        nxt(); flush = 1'b1;
        cyc();
        chk("flush_idle", busy, 0);
        chk("flush_grant", grant, 0);
        nxt(); cyc();
        chk("flush_resel", mux_sel, 2);
        nxt(); cyc();
        chk("flush_regrant", grant, 4'b0100);
        chk("flush_we", reg_write, 1);
        nxt(); cyc();
        nxt(); cyc();

        // Async reset during requester 3's WRITE.
        nxt();
        req = 4'b1000; dest = {5'd5, 5'd0, 5'd0, 5'd0};
        cyc();
        nxt(); cyc();
        chk("r3_grant", grant, 4'b1000);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_model();
        chk("arst_grant", grant, 0);
        chk("arst_we", reg_write, 0);
        @(negedge clk) req = 4'd0;
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nxt(); cyc();
            chk("post_rst_we", reg_write, 0);
        end

        // Randomized traffic with occasional flushes.
        repeat (400) begin
            nxt();
            for (int i = 0; i < 4; i++)
                if (!req[i] && !g_prev[i] && $urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                    dest[i*5 +: 5] = 5'($urandom_range(31));
                end
            flush = ($urandom_range(7) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
